// File: rtl/config_pkg.sv
// Shared configuration for the ALU sequencer: FSM states, response status codes and
// the default ALU wait limit.
package config_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      HDR,
      DATA
   } alu_seq_state_t;

   localparam logic [7:0]  STATUS_OK              = 8'h00;
   localparam logic [7:0]  STATUS_TIMEOUT         = 8'h01;
   localparam logic [15:0] RESP_LEN               = 16'd8;
   localparam int          TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/alu_sequencer.sv
// Accepts one opcode, starts the ALU, waits (bounded) for its result and streams an
// 8-byte response (opcode, status, length, result LSB first) to the UART TX.
module alu_sequencer
   import config_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   input  logic [7:0]  cmd_opcode_i,
   output logic        cmd_ready_o,
   output logic        alu_start_o,
   input  logic        alu_busy_i,
   input  logic        alu_valid_i,
   input  logic [31:0] alu_data_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        timeout_o
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   alu_seq_state_t   state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [2:0]       idx_d;
   logic [7:0]       opcode_q;
   logic [7:0]       status_q;
   logic [31:0]      result_q;
   logic [7:0]       tx_data_q;
   logic             tx_valid_q;
   logic             cmd_ready_q;
   logic             alu_start_q;
   logic             timeout_q;
   logic             tx_fire;

   assign tx_fire = tx_valid_q && tx_ready_i;
   assign idx_d   = idx_q + 3'd1;

   function automatic logic [7:0] resp_byte(input logic [2:0]  idx,
                                            input logic [7:0]  op,
                                            input logic [7:0]  st,
                                            input logic [31:0] res);
      case (idx)
         3'd0:    resp_byte = op;
         3'd1:    resp_byte = st;
         3'd2:    resp_byte = RESP_LEN[7:0];
         3'd3:    resp_byte = RESP_LEN[15:8];
         3'd4:    resp_byte = res[7:0];
         3'd5:    resp_byte = res[15:8];
         3'd6:    resp_byte = res[23:16];
         default: resp_byte = res[31:24];
      endcase
   endfunction

   // NOTE: all state below updates with non-blocking assignments so every branch
   // sees the values registered before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         opcode_q    <= '0;
         status_q    <= STATUS_OK;
         result_q    <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
         alu_start_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         alu_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_q) begin
                  opcode_q    <= cmd_opcode_i;
                  cmd_ready_q <= 1'b0;
                  alu_start_q <= !alu_busy_i;
                  state_q     <= START;
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            // The start pulse is issued while still in START; the cycle after it moves on.
            START: begin
               if (alu_start_q) begin
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end else if (!alu_busy_i) begin
                  alu_start_q <= 1'b1;
               end
            end
            WAIT: begin
               if (alu_valid_i || cnt_q == CNT_LAST) begin
                  result_q   <= alu_valid_i ? alu_data_i : 32'h0;
                  status_q   <= alu_valid_i ? STATUS_OK : STATUS_TIMEOUT;
                  timeout_q  <= !alu_valid_i;
                  idx_q      <= 3'd0;
                  tx_data_q  <= opcode_q;
                  tx_valid_q <= 1'b1;
                  state_q    <= HDR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HDR, DATA: begin
               if (tx_fire) begin
                  if (idx_q == 3'd7) begin
                     tx_valid_q  <= 1'b0;
                     cmd_ready_q <= 1'b1;
                     state_q     <= IDLE;
                  end else begin
                     idx_q     <= idx_d;
                     tx_data_q <= resp_byte(idx_d, opcode_q, status_q, result_q);
                     state_q   <= idx_d[2] ? DATA : HDR;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign alu_start_o = alu_start_q;
   assign tx_data_o   = tx_data_q;
   assign tx_valid_o  = tx_valid_q;
   assign timeout_o   = timeout_q;

endmodule
